// File: rtl/fft_out_capture.sv
// fft_out_capture
//   Sink for the FFT source (output) stream. Each beat is reduced to a
//   magnitude approximation |re|+|im|. Bins 0..FFT_POINT/2-1 of every frame
//   are stored in a two-bank ping-pong RAM. Completed frames are handed to a
//   reader oldest first, using a bank-valid/done handshake.
//
//   Optional feature macro: FFT_CAP_DROP_CNT_EN
//     When defined, the block adds a saturating 16-bit drop_cnt output that
//     counts frame_err pulses.
//
// Ports
//   clk_50m        system clock
//   rst            async reset, active-high
//   fft_src_valid  bin beat valid
//   fft_src_sop    first bin of frame (qualified by valid)
//   fft_src_eop    last bin of frame (qualified by valid)
//   fft_src_real   signed real part
//   fft_src_imag   signed imaginary part
//   fft_src_ready  always 1 after reset; overruns are dropped, not stalled
//   rd_bank_valid  a completed frame is available to read
//   rd_addr        bin index into the available frame
//   rd_data        magnitude at rd_addr, 1-cycle registered read
//   rd_done        1-cycle pulse: reader releases the current frame
//   frame_err      1-cycle pulse on a malformed or dropped frame
//   drop_cnt       (FFT_CAP_DROP_CNT_EN only) saturating frame_err count
//
// state    | meaning
// WAIT_SOP | idle between frames, waiting for a valid sop
// CAPTURE  | storing bins of the current frame into the target bank
// DROP     | no free bank (or frame overran); discarding beats until eop
module fft_out_capture #(
  parameter int FFT_POINT = 256,
  parameter int DATA_W    = 16
) (
  input  logic                         clk_50m,
  input  logic                         rst,
  input  logic                         fft_src_valid,
  input  logic                         fft_src_sop,
  input  logic                         fft_src_eop,
  input  logic signed [DATA_W-1:0]     fft_src_real,
  input  logic signed [DATA_W-1:0]     fft_src_imag,
  output logic                         fft_src_ready,
  output logic                         rd_bank_valid,
  input  logic [$clog2(FFT_POINT)-2:0] rd_addr,
  output logic [DATA_W:0]              rd_data,
  input  logic                         rd_done,
  output logic                         frame_err
`ifdef FFT_CAP_DROP_CNT_EN
  ,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int CNT_W  = $clog2(FFT_POINT);
  localparam int ADDR_W = CNT_W - 1;
  localparam int HALF   = FFT_POINT / 2;
  localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FFT_POINT - 1);

  typedef enum logic [1:0] {
    WAIT_SOP = 2'd0,
    CAPTURE  = 2'd1,
    DROP     = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    bin_cnt_q;
  logic                tgt_bank_q;
  logic                frame_err_q;
  logic                ready_q;

  // stage 1 of the magnitude pipeline, carrying the write/complete intent
  logic                s1_we_q;
  logic                s1_cmpl_q;
  logic                s1_bank_q;
  logic [ADDR_W-1:0]   s1_addr_q;
  logic [DATA_W-1:0]   s1_re_q;
  logic [DATA_W-1:0]   s1_im_q;

  logic [1:0]          full_q, full_d;
  logic                rd_bank_q, rd_bank_d;
  logic [DATA_W:0]     rd_data_q;

  logic [DATA_W:0]     mem [0:2*HALF-1];

  logic [DATA_W-1:0]   abs_re, abs_im;
  logic                rd_release;
  logic [1:0]          clr_mask, set_mask, eff_full;
  logic                both_full, pick_bank;

  // Two's complement negate of the most negative value wraps back to itself,
  // which read as unsigned is exactly 2^(DATA_W-1).
  assign abs_re = fft_src_real[DATA_W-1] ? $unsigned(-fft_src_real) : $unsigned(fft_src_real);
  assign abs_im = fft_src_imag[DATA_W-1] ? $unsigned(-fft_src_imag) : $unsigned(fft_src_imag);

  assign rd_release = rd_done & full_q[rd_bank_q];
  assign clr_mask   = rd_release ? (2'b01 << rd_bank_q) : 2'b00;
  assign set_mask   = s1_cmpl_q  ? (2'b01 << s1_bank_q) : 2'b00;

  // A completion still in stage 1 already owns its bank, so availability at
  // sop counts it as full; a bank released this cycle is free again.
  assign eff_full  = (full_q & ~clr_mask) | set_mask;
  assign full_d    = eff_full;
  assign both_full = &eff_full;
  assign pick_bank = eff_full[0];

  // Keep the read pointer on the oldest full bank. When the pointed bank is
  // empty but the other one holds a frame, that frame is the oldest.
  always_comb begin
    rd_bank_d = rd_bank_q ^ rd_release;
    if (!full_d[rd_bank_d] && full_d[~rd_bank_d]) begin
      rd_bank_d = ~rd_bank_d;
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_SOP;
      bin_cnt_q   <= '0;
      tgt_bank_q  <= 1'b0;
      frame_err_q <= 1'b0;
      s1_we_q     <= 1'b0;
      s1_cmpl_q   <= 1'b0;
      s1_bank_q   <= 1'b0;
      s1_addr_q   <= '0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
    end else begin
      s1_we_q     <= 1'b0;
      s1_cmpl_q   <= 1'b0;
      frame_err_q <= 1'b0;
      s1_re_q     <= abs_re;
      s1_im_q     <= abs_im;
      if (fft_src_valid) begin
        case (state_q)
          WAIT_SOP, DROP: begin
            if (fft_src_sop) begin
              if (fft_src_eop) begin
                frame_err_q <= 1'b1;
                state_q     <= WAIT_SOP;
              end else if (both_full) begin
                frame_err_q <= 1'b1;
                state_q     <= DROP;
              end else begin
                state_q    <= CAPTURE;
                tgt_bank_q <= pick_bank;
                bin_cnt_q  <= CNT_W'(1);
                s1_we_q    <= 1'b1;
                s1_bank_q  <= pick_bank;
                s1_addr_q  <= '0;
              end
            end else if (fft_src_eop && state_q == DROP) begin
              state_q <= WAIT_SOP;
            end
          end
          CAPTURE: begin
            if (fft_src_sop) begin
              // restart in the same bank; partial data there is never exposed
              frame_err_q <= 1'b1;
              if (fft_src_eop) begin
                state_q <= WAIT_SOP;
              end else begin
                bin_cnt_q <= CNT_W'(1);
                s1_we_q   <= 1'b1;
                s1_bank_q <= tgt_bank_q;
                s1_addr_q <= '0;
              end
            end else begin
              if (!bin_cnt_q[CNT_W-1]) begin
                s1_we_q   <= 1'b1;
                s1_bank_q <= tgt_bank_q;
                s1_addr_q <= bin_cnt_q[ADDR_W-1:0];
              end
              if (fft_src_eop) begin
                state_q <= WAIT_SOP;
                if (bin_cnt_q == LAST_BIN) begin
                  s1_cmpl_q <= 1'b1;
                  s1_bank_q <= tgt_bank_q;
                end else begin
                  frame_err_q <= 1'b1;
                end
              end else if (bin_cnt_q == LAST_BIN) begin
                // frame overran without eop: discard it and resync on eop
                frame_err_q <= 1'b1;
                state_q     <= DROP;
              end else begin
                bin_cnt_q <= bin_cnt_q + CNT_W'(1);
              end
            end
          end
          default: state_q <= WAIT_SOP;
        endcase
      end
    end
  end

  // stage 2: sum and RAM write
  always_ff @(posedge clk_50m) begin
    if (s1_we_q) begin
      mem[{s1_bank_q, s1_addr_q}] <= {1'b0, s1_re_q} + {1'b0, s1_im_q};
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      full_q    <= 2'b00;
      rd_bank_q <= 1'b0;
      rd_data_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      full_q    <= full_d;
      rd_bank_q <= rd_bank_d;
      rd_data_q <= mem[{rd_bank_q, rd_addr}];
      ready_q   <= 1'b1;
    end
  end

  assign fft_src_ready = ready_q;
  assign rd_bank_valid = full_q[rd_bank_q];
  assign rd_data       = rd_data_q;
  assign frame_err     = frame_err_q;

`ifdef FFT_CAP_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (frame_err_q && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fft_out_capture.sv
`timescale 1ns/1ps
module tb_fft_out_capture;
  localparam int FFT_POINT = 256;
  localparam int DATA_W    = 16;
  localparam int HALF      = FFT_POINT / 2;

  logic              clk_50m = 1'b0;
  logic              rst = 1'b1;
  logic              fft_src_valid = 1'b0;
  logic              fft_src_sop = 1'b0;
  logic              fft_src_eop = 1'b0;
  logic [DATA_W-1:0] fft_src_real = '0;
  logic [DATA_W-1:0] fft_src_imag = '0;
  logic              fft_src_ready;
  logic              rd_bank_valid;
  logic [6:0]        rd_addr = '0;
  logic [DATA_W:0]   rd_data;
  logic              rd_done = 1'b0;
  logic              frame_err;
`ifdef FFT_CAP_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  always #10 clk_50m = ~clk_50m;

  fft_out_capture #(.FFT_POINT(FFT_POINT), .DATA_W(DATA_W)) dut (
    .clk_50m(clk_50m),
    .rst(rst),
    .fft_src_valid(fft_src_valid),
    .fft_src_sop(fft_src_sop),
    .fft_src_eop(fft_src_eop),
    .fft_src_real(fft_src_real),
    .fft_src_imag(fft_src_imag),
    .fft_src_ready(fft_src_ready),
    .rd_bank_valid(rd_bank_valid),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_done(rd_done),
    .frame_err(frame_err)
`ifdef FFT_CAP_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;
  int exp_err = 0;
  int err_cycles = 0;
  int err_base = 0;
  int model_full_cnt = 0;
  logic [DATA_W:0] exp_q[$];
  bit reader_en = 0;
  bit mon_busy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference magnitude: plain integer |re|+|im|
  function automatic logic [DATA_W:0] mag(input logic [DATA_W-1:0] r, input logic [DATA_W-1:0] i);
    int a, b;
    a = int'($signed(r));
    b = int'($signed(i));
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    return 17'(a + b);
  endfunction

  always @(negedge clk_50m) if (frame_err === 1'b1) err_cycles++;

  task automatic beat(input logic v, input logic s, input logic e,
                      input logic [DATA_W-1:0] r, input logic [DATA_W-1:0] i, input bit gaps);
    if (gaps && $urandom_range(0, 7) == 0) begin
      fft_src_valid = 1'b0;
      fft_src_sop   = 1'($urandom);
      fft_src_eop   = 1'($urandom);
      fft_src_real  = 16'($urandom);
      fft_src_imag  = 16'($urandom);
      @(negedge clk_50m);
    end
    fft_src_valid = v;
    fft_src_sop   = s;
    fft_src_eop   = e;
    fft_src_real  = r;
    fft_src_imag  = i;
    @(negedge clk_50m);
  endtask

  function automatic logic [DATA_W-1:0] rnd_sample();
    case ($urandom_range(0, 15))
      0: return 16'h8000;
      1: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // mode: 0 random, 1 ramp, 2 all -32768, 3 eop at arg, 4 sop restart at arg, 5 sop&eop single beat
  task automatic send_frame(input int mode, input int arg, input bit gaps);
    logic [DATA_W-1:0] re[FFT_POINT];
    logic [DATA_W-1:0] im[FFT_POINT];
    bit full;
    for (int k = 0; k < FFT_POINT; k++) begin
      case (mode)
        1: begin re[k] = 16'(k); im[k] = 16'(-k); end
        2: begin re[k] = 16'h8000; im[k] = 16'h8000; end
        default: begin re[k] = rnd_sample(); im[k] = rnd_sample(); end
      endcase
    end
    full = (model_full_cnt == 2);
    if (mode == 3) begin
      for (int k = 0; k <= arg; k++) beat(1'b1, k == 0, k == arg, re[k], im[k], gaps);
      exp_err++;
    end else if (mode == 5) begin
      beat(1'b1, 1'b1, 1'b1, re[0], im[0], gaps);
      exp_err++;
    end else begin
      if (mode == 4)
        for (int k = 0; k < arg; k++) beat(1'b1, k == 0, 1'b0, rnd_sample(), rnd_sample(), gaps);
      for (int k = 0; k < FFT_POINT; k++)
        beat(1'b1, k == 0, k == FFT_POINT - 1, re[k], im[k], gaps);
      if (full) begin
        exp_err += (mode == 4) ? 2 : 1;
      end else begin
        exp_err += (mode == 4) ? 1 : 0;
        model_full_cnt++;
        for (int k = 0; k < HALF; k++) exp_q.push_back(mag(re[k], im[k]));
      end
    end
    fft_src_valid = 1'b0;
    fft_src_sop   = 1'b0;
    fft_src_eop   = 1'b0;
  endtask

  task automatic junk_beats(input int n);
    for (int k = 0; k < n; k++) beat(1'b1, 1'b0, 1'($urandom), rnd_sample(), rnd_sample(), 1'b0);
    fft_src_valid = 1'b0;
    fft_src_eop   = 1'b0;
  endtask

  // reader / scoreboard monitor
  initial begin
    int nbad;
    int bad_a;
    logic [DATA_W:0] bad_got, bad_exp;
    bit have;
    forever begin
      @(negedge clk_50m);
      if (reader_en && rd_bank_valid === 1'b1 && rst === 1'b0) begin
        mon_busy = 1;
        have = (exp_q.size() >= HALF);
        chk("frame_expected_by_model", 32'(have), 1);
        nbad = 0;
        bad_a = 0;
        bad_got = '0;
        bad_exp = '0;
        for (int a = 0; a < HALF; a++) begin
          rd_addr = 7'(a);
          @(negedge clk_50m);
          if (have && rd_data !== exp_q[a]) begin
            if (nbad == 0) begin bad_a = a; bad_got = rd_data; bad_exp = exp_q[a]; end
            nbad++;
          end
        end
        chk($sformatf("frame_bins_bad(first addr %0d got %0h exp %0h)", bad_a, bad_got, bad_exp), 32'(nbad), 0);
        if (have) begin
          repeat (HALF) void'(exp_q.pop_front());
          model_full_cnt--;
        end
        rd_done = 1'b1;
        @(negedge clk_50m);
        rd_done = 1'b0;
        mon_busy = 0;
      end
    end
  end

  task automatic drain();
    int t;
    t = 0;
    reader_en = 1;
    while ((exp_q.size() != 0 || mon_busy || rd_bank_valid === 1'b1) && t < 1500) begin
      @(negedge clk_50m);
      t++;
    end
    chk("drain_in_time", 32'(t < 1500), 1);
    reader_en = 0;
    @(negedge clk_50m);
    chk("drain_bank_empty", 32'(rd_bank_valid), 0);
    chk("frame_err_cycles", 32'(err_cycles), 32'(exp_err));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    @(negedge clk_50m);
    @(negedge clk_50m);
    chk("reset_ready", 32'(fft_src_ready), 0);
    chk("reset_bank_valid", 32'(rd_bank_valid), 0);
    chk("reset_rd_data", 32'(rd_data), 0);
    chk("reset_frame_err", 32'(frame_err), 0);
    rst = 1'b0;
    @(negedge clk_50m);
    chk("ready_after_reset", 32'(fft_src_ready), 1);

    // T1 ramp frame with latency checks
    send_frame(1, 0, 1'b0);
    chk("t1_valid_1cyc_after_eop", 32'(rd_bank_valid), 0);
    @(negedge clk_50m);
    chk("t1_valid_2cyc_after_eop", 32'(rd_bank_valid), 1);
    rd_addr = 7'd5;
    @(negedge clk_50m);
    chk("t1_rd_addr5", 32'(rd_data), 10);
    rd_addr = 7'd127;
    @(negedge clk_50m);
    chk("t1_rd_addr127", 32'(rd_data), 254);
    drain();

    // T2 most negative inputs
    send_frame(2, 0, 1'b1);
    drain();

    // rd_done with nothing stored is ignored
    rd_done = 1'b1;
    @(negedge clk_50m);
    rd_done = 1'b0;
    @(negedge clk_50m);
    chk("done_while_empty", 32'(rd_bank_valid), 0);

    // T3 three back-to-back frames, reader idle
    junk_beats(3);
    for (int f = 0; f < 3; f++) send_frame(0, 0, 1'b0);
    repeat (4) @(negedge clk_50m);
    chk("t3_bank_valid", 32'(rd_bank_valid), 1);
    chk("t3_err_cycles", 32'(err_cycles), 32'(exp_err));
`ifdef FFT_CAP_DROP_CNT_EN
    chk("t3_drop_cnt", 32'(drop_cnt), 32'(exp_err));
`endif
    drain();

    // T4 short frame then a good one
    send_frame(3, 100, 1'b1);
    repeat (4) @(negedge clk_50m);
    chk("t4_bank_valid_low", 32'(rd_bank_valid), 0);
    chk("t4_err_cycles", 32'(err_cycles), 32'(exp_err));
    send_frame(0, 0, 1'b1);
    drain();

    // T5 sop restart at bin 50
    send_frame(4, 50, 1'b1);
    drain();

    // random mix with the reader idle, draining now and then
    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: mode = 0;
        3: mode = 3;
        4: mode = 4;
        default: mode = 5;
      endcase
      send_frame(mode, $urandom_range(1, FFT_POINT - 2), 1'b1);
      if ($urandom_range(0, 1) == 0) junk_beats($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    // reader running concurrently with capture
    reader_en = 1;
    for (int n = 0; n < 5; n++) begin
      case ($urandom_range(0, 3))
        0, 1: mode = 0;
        2: mode = 3;
        default: mode = 4;
      endcase
      send_frame(mode, $urandom_range(1, FFT_POINT - 2), 1'b1);
    end
    drain();

    // T6 reset mid-frame with a stored frame pending
    send_frame(0, 0, 1'b1);
    for (int k = 0; k <= 80; k++) beat(1'b1, k == 0, 1'b0, rnd_sample(), rnd_sample(), 1'b0);
    rst = 1'b1;
    fft_src_valid = 1'b0;
    @(negedge clk_50m);
    chk("t6_reset_ready", 32'(fft_src_ready), 0);
    chk("t6_reset_bank_valid", 32'(rd_bank_valid), 0);
    chk("t6_reset_rd_data", 32'(rd_data), 0);
    chk("t6_reset_frame_err", 32'(frame_err), 0);
`ifdef FFT_CAP_DROP_CNT_EN
    chk("t6_reset_drop_cnt", 32'(drop_cnt), 0);
`endif
    exp_q.delete();
    model_full_cnt = 0;
    err_base = exp_err;
    rst = 1'b0;
    chk("t6_ready_low_at_release", 32'(fft_src_ready), 0);
    @(negedge clk_50m);
    chk("t6_ready_after_release", 32'(fft_src_ready), 1);
    send_frame(3, 20, 1'b0);
    send_frame(0, 0, 1'b1);
    repeat (3) @(negedge clk_50m);
    chk("t6_new_frame_valid", 32'(rd_bank_valid), 1);
    drain();
`ifdef FFT_CAP_DROP_CNT_EN
    chk("final_drop_cnt", 32'(drop_cnt), 32'(exp_err - err_base));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
